riscv_serial_divider: RTL and testbench

//  Multi-cycle radix-2 integer divider for RV32M DIV/DIVU/REM/REMU. Sits in EX beside the ALU.

---
 rtl/riscv_serial_divider.sv | 184 ++++++++++++++++++
 tb/tb_riscv_serial_divider.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_serial_divider.sv
// ============================================================================
//  Module      : riscv_serial_divider
//  Description : Multi-cycle radix-2 restoring divider for RV32M
//                DIV / DIVU / REM / REMU. One quotient bit per cycle; a
//                result is returned through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      core clock
//    rst          in   1      synchronous reset, active-high
//    enable_i     in   1      request a divide op this cycle
//    operator_i   in   7      ALU opcode; bit0 = signed, bit1 = remainder
//    op_a_i       in   WIDTH  dividend
//    op_b_i       in   WIDTH  divisor
//    flush_i      in   1      abort any op in flight
//    ready_o      out  1      idle; op accepted when enable_i & ready_o
//    valid_o      out  1      result_o is valid
//    ex_ready_i   in   1      result consumed when valid_o & ex_ready_i
//    result_o     out  WIDTH  quotient or remainder
//  Configuration macro
//    SERIAL_DIV_FAST_ZERO_EN : a zero divisor skips the iterations and goes
//                              straight to FINISH (valid one cycle later).
// ============================================================================
`default_nettype none

module riscv_serial_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [6:0]       operator_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ex_ready_i,
    output logic [WIDTH-1:0] result_o
);

    // Divide opcodes share the upper five bits; the low two bits select
    // signedness (bit0) and quotient/remainder (bit1).
    localparam logic [6:0]       C_ALU_DIVU = 7'b0110000;
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;      // partial remainder (low WIDTH bits)
    logic [WIDTH-1:0]   r_quot;     // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   r_div;      // |divisor|
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_is_rem;
    logic               r_div_zero;
    logic               r_ready;
    logic               r_valid;
    logic [WIDTH-1:0]   r_result;

    logic               w_op_is_div;
    logic               w_accept;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_b_zero;
    logic               w_fast_zero;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_quot_fin;
    logic [WIDTH-1:0]   w_rem_fin;

    assign w_op_is_div = (operator_i[6:2] == C_ALU_DIVU[6:2]);
    assign w_accept    = (r_state == S_IDLE) && enable_i && !flush_i && w_op_is_div;

    assign w_sign_a = operator_i[0] & op_a_i[WIDTH-1];
    assign w_sign_b = operator_i[0] & op_b_i[WIDTH-1];
    assign w_abs_a  = w_sign_a ? (~op_a_i + C_ONE) : op_a_i;
    assign w_abs_b  = w_sign_b ? (~op_b_i + C_ONE) : op_b_i;
    assign w_b_zero = (op_b_i == '0);

`ifdef SERIAL_DIV_FAST_ZERO_EN
    assign w_fast_zero = w_b_zero;
`else
    assign w_fast_zero = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the WIDTH+1 bit
    // partial remainder and keep the difference if it did not go negative.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_q_bit = ~w_diff[WIDTH];

    // Divide-by-zero forces an all-ones quotient so the sign fix-up cannot
    // disturb it. The remainder path already yields |a|, and negating by
    // sign_a restores the raw dividend. The signed-overflow case falls out
    // naturally because -0x80000000 wraps back to 0x80000000.
    assign w_quot_fin = r_div_zero ? {WIDTH{1'b1}} :
                        (r_neg_q ? (~r_quot + C_ONE) : r_quot);
    assign w_rem_fin  = r_neg_r ? (~r_rem + C_ONE) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_div      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_rem   <= 1'b0;
            r_div_zero <= 1'b0;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_result   <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_quot     <= w_abs_a;
                        r_div      <= w_abs_b;
                        // The fast zero path skips the iterations, so seed
                        // the remainder with what they would have produced.
                        r_rem      <= w_fast_zero ? w_abs_a : '0;
                        r_neg_q    <= w_sign_a ^ w_sign_b;
                        r_neg_r    <= w_sign_a;
                        r_is_rem   <= operator_i[1];
                        r_div_zero <= w_b_zero;
                        r_cnt      <= C_CNT_LOAD;
                        r_ready    <= 1'b0;
                        r_state    <= w_fast_zero ? S_FINISH : S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_rem  <= w_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quot <= {r_quot[WIDTH-2:0], w_q_bit};
                    r_cnt  <= r_cnt - C_CNT_ONE;
                    if (r_cnt == '0) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    // First FINISH cycle registers the corrected result;
                    // afterwards hold it until downstream takes it.
                    if (!r_valid) begin
                        r_valid  <= 1'b1;
                        r_result <= r_is_rem ? w_rem_fin : w_quot_fin;
                    end else if (ex_ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_riscv_serial_divider.sv
// ============================================================================
//  Module      : tb_riscv_serial_divider
//  Description : Directed self-checking bench for riscv_serial_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_serial_divider;

    localparam logic [6:0] ALU_DIVU = 7'b0110000;
    localparam logic [6:0] ALU_DIV  = 7'b0110001;
    localparam logic [6:0] ALU_REMU = 7'b0110010;
    localparam logic [6:0] ALU_REM  = 7'b0110011;
    localparam logic [6:0] ALU_ADD  = 7'b0011000;
    localparam logic [6:0] ALU_NODIV = 7'b0110111;

    localparam int LAT = 33;
`ifdef SERIAL_DIV_FAST_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic        clk;
    logic        rst;
    logic        enable_i;
    logic [6:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        ready_o;
    logic        valid_o;
    logic        ex_ready_i;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;

    riscv_serial_divider #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (enable_i),
        .operator_i (operator_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .flush_i    (flush_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .ex_ready_i (ex_ready_i),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for valid, check latency/result, then hand it off.
    task automatic run_op(input string name, input logic [6:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", name, ready_o);
        end
        enable_i   = 1'b1;
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        tick();
        enable_i = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (valid_o !== 1'b1 && lat < 100);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (result_o !== exp) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, result_o, exp);
        end
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_in_finish: got %b expected 0", name, ready_o);
        end
        ex_ready_i = 1'b1;
        tick();
        ex_ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: valid=%b ready=%b expected valid=0 ready=1",
                     name, valid_o, ready_o);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", ready_o);
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", valid_o);
        end
        checks++;
        if (result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", result_o);
        end
    endtask

    // Consecutive calls hand off and re-issue on adjacent cycles.
    task automatic test_back_to_back;
        run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'h0000000E, LAT);
        run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'h00000002, LAT);
        run_op("div_m7_2",   ALU_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT);
        run_op("rem_m7_2",   ALU_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT);
        run_op("div_100_m7", ALU_DIV,  32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, LAT);
        run_op("rem_100_m7", ALU_REM,  32'd100, 32'hFFFFFFF9, 32'h00000002, LAT);
    endtask

    task automatic test_div_zero;
        run_op("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, ZLAT);
        run_op("remu_5_0", ALU_REMU, 32'd5, 32'd0, 32'h00000005, ZLAT);
        run_op("div_m5_0", ALU_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, ZLAT);
        run_op("rem_m5_0", ALU_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, ZLAT);
    endtask

    task automatic test_overflow;
        run_op("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT);
        run_op("rem_ovf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT);
    endtask

    task automatic test_invalid_op;
        int seen;
        enable_i   = 1'b1;
        operator_i = ALU_ADD;
        op_a_i     = 32'd10;
        op_b_i     = 32'd2;
        tick();
        operator_i = ALU_NODIV;
        tick();
        enable_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL invalid_op_ready: got %b expected 1", ready_o);
        end
        seen = 0;
        repeat (40) begin
            tick();
            if (valid_o === 1'b1 || ready_o !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL invalid_op_idle: got %0d busy/valid cycles expected 0", seen);
        end
    endtask

    task automatic test_hold;
        int lat;
        enable_i   = 1'b1;
        operator_i = ALU_DIVU;
        op_a_i     = 32'h12345678;
        op_b_i     = 32'h00000010;
        tick();
        enable_i = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (valid_o !== 1'b1 && lat < 100);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL hold_latency: got %0d expected %0d", lat, LAT);
        end
        // A competing request during the stall must not be taken.
        enable_i   = 1'b1;
        operator_i = ALU_DIVU;
        op_a_i     = 32'd50;
        op_b_i     = 32'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'h01234567) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b ready=%b result=%h expected 1 0 01234567",
                         i, valid_o, ready_o, result_o);
            end
        end
        enable_i   = 1'b0;
        ex_ready_i = 1'b1;
        tick();
        ex_ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid=%b ready=%b expected 0 1", valid_o, ready_o);
        end
        lat = 0;
        repeat (40) begin
            tick();
            if (valid_o === 1'b1) lat++;
        end
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL hold_no_accept: got %0d valid cycles expected 0", lat);
        end
    endtask

    task automatic test_flush;
        int seen;
        enable_i   = 1'b1;
        operator_i = ALU_DIVU;
        op_a_i     = 32'd1000;
        op_b_i     = 32'd3;
        tick();
        enable_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_mid: ready=%b valid=%b expected 1 0", ready_o, valid_o);
        end
        // Flush also beats a simultaneous request in IDLE.
        enable_i = 1'b1;
        flush_i  = 1'b1;
        tick();
        enable_i = 1'b0;
        flush_i  = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (valid_o === 1'b1 || ready_o !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_quiet: got %0d busy/valid cycles expected 0", seen);
        end
        run_op("divu_9_3_after_flush", ALU_DIVU, 32'd9, 32'd3, 32'h00000003, LAT);
    endtask

    task automatic test_reset_mid_op;
        enable_i   = 1'b1;
        operator_i = ALU_DIV;
        op_a_i     = 32'hFFFFFFF9;
        op_b_i     = 32'd2;
        tick();
        enable_i = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_op: ready=%b valid=%b result=%h expected 1 0 0",
                     ready_o, valid_o, result_o);
        end
        run_op("remu_1000_3", ALU_REMU, 32'd1000, 32'd3, 32'h00000001, LAT);
        run_op("divu_1000_3", ALU_DIVU, 32'd1000, 32'd3, 32'h0000014D, LAT);
    endtask

    initial begin
        rst        = 1'b1;
        enable_i   = 1'b0;
        operator_i = 7'd0;
        op_a_i     = 32'd0;
        op_b_i     = 32'd0;
        flush_i    = 1'b0;
        ex_ready_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_div_zero();
        test_overflow();
        test_invalid_op();
        test_hold();
        test_flush();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
